idma_desc64_arb: RTL and testbench
==================================

Name: idma_desc64_arb

Overview:
- Shares one iDMA backend between NumReq idma_desc64 descriptor frontends.
- Round-robin arbitration on the frontends' idma_req streams.
- Records the issuing requester of every accepted transfer in an in-order ID FIFO, so each in-order backend response returns to its owner.
- Sits between the idma_desc64_top instances and the backend, in the desc64 system wrapper.

Parameters:
- NumReq, 2: number of descriptor frontends (2..8).
- MaxOutstanding, 4: order-FIFO depth, i.e. maximum transfers in flight in the backend (power of two, at least 2).
- idma_req_t, logic: backend request type.
- idma_rsp_t, logic: backend response type.
- IdxWidth, $clog2(NumReq): requester index width (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NumReq x idma_req_t  frontend requests
- req_valid_i  in  NumReq  frontend request valid
- req_ready_o  out  NumReq  frontend request ready
- rsp_o  out  NumReq x idma_rsp_t  responses routed to frontends
- rsp_valid_o  out  NumReq  response valid
- rsp_ready_i  in  NumReq  response ready
- busy_o  out  NumReq  per-frontend busy
- idma_req_o  out  idma_req_t  backend request
- idma_req_valid_o  out  1  backend request valid
- idma_req_ready_i  in  1  backend request ready
- idma_rsp_i  in  idma_rsp_t  backend response
- idma_rsp_valid_i  in  1  backend response valid
- idma_rsp_ready_o  out  1  backend response ready
- idma_busy_i  in  1  backend busy

Behaviour:
- Reset:
  - RR pointer = 0; lock = 0; order FIFO empty; all pending counters = 0.
  - All valid/ready outputs = 0 (combinationally, since the FIFO is empty and no requests are present).
- Arbitration:
  - Among asserted req_valid_i, grant the first index at or after the RR pointer, wrapping modulo NumReq.
  - Request path is combinational, zero latency: idma_req_o = req_i[grant]; idma_req_valid_o = any valid AND FIFO not full; req_ready_o[grant] = idma_req_ready_i AND FIFO not full; all other ready = 0.
- Stability:
  - If idma_req_valid_o=1 and idma_req_ready_i=0, register lock=1 with the locked index. The grant stays fixed until the handshake completes.
  - A locked requester dropping its valid is a protocol violation (assertion).
- Backend request handshake:
  - Push the grant index into the order FIFO.
  - RR pointer <= grant+1 (mod NumReq).
  - Clear lock.
  - pending[grant]++.
- FIFO full: idma_req_valid_o=0 and all req_ready_o=0. A pop in the same cycle does not unblock the push; the push waits one cycle.
- Response routing:
  - head = FIFO head index.
  - rsp_o[all] = idma_rsp_i.
  - rsp_valid_o[head] = idma_rsp_valid_i AND FIFO not empty.
  - idma_rsp_ready_o = rsp_ready_i[head] AND FIFO not empty.
- Response handshake: pop the FIFO; pending[head]--.
- FIFO empty: idma_rsp_ready_o=0. idma_rsp_valid_i=1 while empty is an assertion failure. A response in the same cycle as the first push is not accepted.
- Simultaneous push and pop (FIFO neither empty nor full): both take effect. If push and pop hit the same requester index, its pending count is unchanged.
- Pending counters: width $clog2(MaxOutstanding+1); never wrap; overflow and underflow are assertions.
- busy_o[i] = (pending[i] != 0) OR (lock AND locked index == i).
- idma_busy_i AND all pending == 0 raises an assertion only (no functional effect).
- Reset mid-operation: all state cleared asynchronously. In-flight backend transfers are the system's responsibility; the backend is reset together with this block.

Optional Feature:
- Macro IDMA_DESC64_ARB_PERF_EN.
- When defined: adds output port perf_cnt_o (NumReq x 32), one free-running counter per requester. Each counts accepted backend request handshakes; cleared on reset; wraps at 2^32-1 to 0.
- When undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package idma_desc64_arb_pkg holds:
  - typedef idx_t (requester index);
  - typedef pend_cnt_t;
  - localparam PerfCntWidth = 32.
- Sub-module: the order FIFO is one instance of common_cells fifo_v3 (DATA_WIDTH=IdxWidth, DEPTH=MaxOutstanding, FALL_THROUGH=0).
- Arbitration, lock and counters are local logic.

Test Plan:
- Round-robin fairness: NumReq=2, both valid continuously, ready=1 → grants 0,1,0,1; FIFO contents 0,1,0,1; responses returned to 0,1,0,1 in order.
- Lock: req0 valid with ready=0 for 3 cycles, req1 raises valid in cycle 1 → idma_req_o stays req_i[0] unchanged; req1 granted only after the req0 handshake.
- FIFO full: MaxOutstanding=4, issue 4 with no responses → 5th blocked (valid_o=0). Pop one response → 5th accepted the following cycle.
- Response backpressure: head=1, rsp_ready_i[1]=0 for 5 cycles → idma_rsp_ready_o=0 throughout, rsp_valid_o[1]=1, nothing popped. Assert ready → single pop.
- Busy and pending: req1 issues 2, receives 1 response → busy_o[1]=1, busy_o[0]=0. Second response → busy_o[1]=0.
- Reset: assert rst_ni=0 with 3 in flight and lock=1 → all outputs 0 immediately; after release, FIFO is empty and grant restarts at index 0.

Source files
------------

// File: rtl/idma_desc64_arb_pkg.sv
// idma_desc64_arb_pkg: shared types, limits and helpers for the desc64 backend arbiter
package idma_desc64_arb_pkg;
  localparam int unsigned MaxNumReq = 8;
  localparam int unsigned MaxOutstandingLimit = 128;
  localparam int unsigned PerfCntWidth = 32;
  typedef logic [$clog2(MaxNumReq)-1:0] idx_t;
  typedef logic [$clog2(MaxOutstandingLimit+1)-1:0] pend_cnt_t;
  function automatic idx_t rr_next(idx_t idx, int unsigned n);
    return (int'(idx) + 1 >= n) ? '0 : idx + idx_t'(1);
  endfunction
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: common_cells-compatible synchronous FIFO (DEPTH must be a power of two)
// Ports: clk_i/rst_ni (async active-low), flush_i clears contents, full_o/empty_o status,
//        push_i/data_i write side, pop_i/data_o read side (data_o shows the head entry).
// Push while full and pop while empty are ignored.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [AddrW-1:0] rd_q, wr_q;
  logic [AddrW:0] cnt_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic bypass, do_push, do_pop;
  // Fall-through: an entry pushed into an empty FIFO is visible at once and
  // is consumed without being stored if popped in the same cycle.
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i;
  assign full_o  = cnt_q == (AddrW+1)'(DEPTH);
  assign empty_o = (cnt_q == '0) && !bypass;
  assign data_o  = bypass ? data_i : mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o && !bypass;
  assign do_push = push_i && !full_o && !(bypass && pop_i);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      mem_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AddrW'(1);
      end
      if (do_pop) rd_q <= rd_q + AddrW'(1);
      cnt_q <= cnt_q + (AddrW+1)'(do_push) - (AddrW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/idma_desc64_arb.sv
// idma_desc64_arb: round-robin share of one iDMA backend among NumReq desc64 frontends
// Ports: req_i/req_valid_i/req_ready_o frontend requests; rsp_o/rsp_valid_o/rsp_ready_i
//        responses routed back to their owner; busy_o per-frontend in-flight/locked flag;
//        idma_req_*/idma_rsp_* backend side; idma_busy_i backend busy (checked only).
// Optional: define IDMA_DESC64_ARB_PERF_EN to add perf_cnt_o, per-requester counts of
//           accepted backend requests (wrapping 32-bit).
// Outputs' valid/ready are forced low while rst_ni is asserted.
module idma_desc64_arb
  import idma_desc64_arb_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         idma_req_t     = logic,
  parameter type         idma_rsp_t     = logic,
  parameter int unsigned IdxWidth       = $clog2(NumReq)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  idma_req_t [NumReq-1:0]       req_i,
  input  logic      [NumReq-1:0]       req_valid_i,
  output logic      [NumReq-1:0]       req_ready_o,
  output idma_rsp_t [NumReq-1:0]       rsp_o,
  output logic      [NumReq-1:0]       rsp_valid_o,
  input  logic      [NumReq-1:0]       rsp_ready_i,
  output logic      [NumReq-1:0]       busy_o,
  output idma_req_t                    idma_req_o,
  output logic                         idma_req_valid_o,
  input  logic                         idma_req_ready_i,
  input  idma_rsp_t                    idma_rsp_i,
  input  logic                         idma_rsp_valid_i,
  output logic                         idma_rsp_ready_o,
  input  logic                         idma_busy_i
`ifdef IDMA_DESC64_ARB_PERF_EN
  ,output logic [NumReq-1:0][PerfCntWidth-1:0] perf_cnt_o
`endif
);
  localparam int unsigned PendW = $clog2(MaxOutstanding + 1);
  logic [IdxWidth-1:0] rr_q, lock_idx_q, arb_idx, cand, gnt, head;
  logic lock_q, full, empty, push, pop, req_go;
  logic [NumReq-1:0] pend_nz;
  // Scan from the farthest offset down so the first valid at/after rr_q wins.
  always_comb begin
    arb_idx = rr_q;
    cand = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      cand = IdxWidth'((int'(rr_q) + k) % NumReq);
      if (req_valid_i[cand]) arb_idx = cand;
    end
  end
  assign gnt              = lock_q ? lock_idx_q : arb_idx;
  assign req_go           = rst_ni && (|req_valid_i) && !full;
  assign idma_req_o       = req_i[gnt];
  assign idma_req_valid_o = req_go;
  assign req_ready_o      = (req_go && idma_req_ready_i) ? NumReq'(1) << gnt : '0;
  assign push             = idma_req_valid_o && idma_req_ready_i;
  assign rsp_o            = {NumReq{idma_rsp_i}};
  assign rsp_valid_o      = (idma_rsp_valid_i && !empty) ? NumReq'(1) << head : '0;
  assign idma_rsp_ready_o = rsp_ready_i[head] && !empty;
  assign pop              = idma_rsp_valid_i && idma_rsp_ready_o;
  // The push is gated by full above, so a same-cycle pop never lets a full FIFO accept.
  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (IdxWidth),
    .DEPTH        (MaxOutstanding)
  ) i_order_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (full),
    .empty_o (empty),
    .data_i  (gnt),
    .push_i  (push),
    .data_o  (head),
    .pop_i   (pop)
  );
  // Lock the grant while the backend stalls a presented request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (push) begin
      rr_q   <= IdxWidth'(rr_next(idx_t'(gnt), NumReq));
      lock_q <= 1'b0;
    end else if (idma_req_valid_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= gnt;
    end
  end
  for (genvar i = 0; i < NumReq; i++) begin : g_req
    logic inc, dec;
    logic [PendW-1:0] pend_q;
    assign inc        = push && (gnt == IdxWidth'(i));
    assign dec        = pop && (head == IdxWidth'(i));
    assign pend_nz[i] = pend_q != '0;
    assign busy_o[i]  = pend_nz[i] || (lock_q && (lock_idx_q == IdxWidth'(i)));
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) pend_q <= '0;
      else pend_q <= pend_q + PendW'(inc) - PendW'(dec);
    end
`ifdef IDMA_DESC64_ARB_PERF_EN
    logic [PerfCntWidth-1:0] perf_q;
    assign perf_cnt_o[i] = perf_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) perf_q <= '0;
      else perf_q <= perf_q + PerfCntWidth'(inc);
    end
`endif
    a_pend_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(inc && !dec && pend_q == PendW'(MaxOutstanding)));
    a_pend_udf: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(dec && !inc && pend_q == '0));
  end
  a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> req_valid_i[lock_idx_q]);
  a_rsp_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    idma_rsp_valid_i |-> !empty);
  a_busy_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    idma_busy_i |-> |pend_nz);
endmodule

// File: tb/tb_idma_desc64_arb.sv
// tb_idma_desc64_arb: vector table plus reset sequence with a response-owner scoreboard
module tb_idma_desc64_arb;
  typedef logic [7:0] dat_t;
  typedef struct packed {
    logic [1:0] rv;
    logic       ri;
    logic       rspv;
    logic [1:0] rspr;
    logic       ev;
    dat_t       ereq;
    logic [1:0] erdy;
    logic [1:0] ersv;
    logic       ersr;
    logic [1:0] ebusy;
  } vec_t;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  dat_t [1:0] req;
  dat_t [1:0] rsp;
  dat_t ireq, irsp;
  logic [1:0] rv, rdy, rsv, rspr, busy;
  logic ivalid, iready, irspv, irspr, ibusy;
  int n_vec = 0;
  int n_err = 0;
  int sb[$];
  int owner;
  vec_t vt[24];
  idma_desc64_arb #(
    .NumReq(2), .MaxOutstanding(4), .idma_req_t(dat_t), .idma_rsp_t(dat_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .req_valid_i(rv), .req_ready_o(rdy),
    .rsp_o(rsp), .rsp_valid_o(rsv), .rsp_ready_i(rspr), .busy_o(busy),
    .idma_req_o(ireq), .idma_req_valid_o(ivalid), .idma_req_ready_i(iready),
    .idma_rsp_i(irsp), .idma_rsp_valid_i(irspv), .idma_rsp_ready_o(irspr),
    .idma_busy_i(ibusy)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] v, input logic r, input logic sv, input logic [1:0] sr);
    rv = v;
    iready = r;
    irspv = sv;
    rspr = sr;
    #2;
  endtask
  initial begin
    vt[0]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'hA0, 2'b00, 2'b00, 1'b0, 2'b00};
    vt[1]  = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 8'hA0, 2'b01, 2'b00, 1'b0, 2'b00};
    vt[2]  = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 8'hB1, 2'b10, 2'b00, 1'b0, 2'b01};
    vt[3]  = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 8'hA0, 2'b01, 2'b00, 1'b0, 2'b11};
    vt[4]  = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 8'hB1, 2'b10, 2'b00, 1'b0, 2'b11};
    vt[5]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 8'hA0, 2'b00, 2'b01, 1'b1, 2'b11};
    vt[6]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 8'hA0, 2'b01, 2'b10, 1'b1, 2'b11};
    vt[7]  = '{2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 8'hB1, 2'b00, 2'b01, 1'b1, 2'b11};
    for (int k = 8; k < 13; k++)
      vt[k] = '{2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 8'hB1, 2'b00, 2'b10, 1'b0, 2'b11};
    vt[13] = '{2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 8'hB1, 2'b00, 2'b10, 1'b1, 2'b11};
    vt[14] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 8'hB1, 2'b00, 2'b01, 1'b1, 2'b01};
    vt[15] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'hB1, 2'b00, 2'b00, 1'b0, 2'b00};
    vt[16] = '{2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 8'hA0, 2'b00, 2'b00, 1'b0, 2'b00};
    vt[17] = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 8'hA0, 2'b00, 2'b00, 1'b0, 2'b01};
    vt[18] = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 8'hA0, 2'b01, 2'b00, 1'b0, 2'b01};
    vt[19] = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 8'hB1, 2'b00, 2'b00, 1'b0, 2'b01};
    vt[20] = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 8'hB1, 2'b10, 2'b00, 1'b0, 2'b11};
    vt[21] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 8'hA0, 2'b00, 2'b01, 1'b1, 2'b11};
    vt[22] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 8'hA0, 2'b00, 2'b10, 1'b1, 2'b10};
    vt[23] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'hA0, 2'b00, 2'b00, 1'b0, 2'b00};
    req[0] = 8'hA0;
    req[1] = 8'hB1;
    irsp = 8'h5C;
    ibusy = 1'b0;
    rv = 2'b00;
    iready = 1'b0;
    irspv = 1'b0;
    rspr = 2'b00;
    tick();
    tick();
    rst_ni = 1'b1;
    foreach (vt[k]) begin
      drive(vt[k].rv, vt[k].ri, vt[k].rspv, vt[k].rspr);
      chk("req_valid", k, 32'(ivalid), 32'(vt[k].ev));
      chk("req_data", k, 32'(ireq), 32'(vt[k].ereq));
      chk("req_ready", k, 32'(rdy), 32'(vt[k].erdy));
      chk("rsp_valid", k, 32'(rsv), 32'(vt[k].ersv));
      chk("rsp_ready", k, 32'(irspr), 32'(vt[k].ersr));
      chk("busy", k, 32'(busy), 32'(vt[k].ebusy));
      chk("rsp_data", k, 32'(rsp), 32'h5C5C);
      if (vt[k].rspv && vt[k].ersr) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_owner @%0d: response with empty scoreboard", k);
        end else begin
          owner = sb.pop_front();
          chk("rsp_owner", k, 32'(rsv), 32'(2'b01 << owner));
        end
      end
      if (vt[k].ev && vt[k].ri) sb.push_back(vt[k].erdy[1] ? 1 : 0);
      tick();
    end
    chk("sb_drained", 100, 32'(sb.size()), 32'd0);
    repeat (3) begin
      drive(2'b01, 1'b1, 1'b0, 2'b00);
      tick();
    end
    drive(2'b10, 1'b0, 1'b0, 2'b00);
    chk("pre_lock_busy", 200, 32'(busy), 32'b01);
    tick();
    drive(2'b10, 1'b0, 1'b0, 2'b11);
    chk("lock_busy", 201, 32'(busy), 32'b11);
    chk("lock_data", 201, 32'(ireq), 32'hB1);
    rst_ni = 1'b0;
    #1;
    chk("rst_req_valid", 202, 32'(ivalid), 32'd0);
    chk("rst_req_ready", 202, 32'(rdy), 32'd0);
    chk("rst_busy", 202, 32'(busy), 32'd0);
    chk("rst_rsp_valid", 202, 32'(rsv), 32'd0);
    chk("rst_rsp_ready", 202, 32'(irspr), 32'd0);
    tick();
    rst_ni = 1'b1;
    drive(2'b11, 1'b1, 1'b0, 2'b11);
    chk("post_rst_data", 203, 32'(ireq), 32'hA0);
    chk("post_rst_ready", 203, 32'(rdy), 32'b01);
    chk("post_rst_empty", 203, 32'(irspr), 32'd0);
    chk("post_rst_busy", 203, 32'(busy), 32'd0);
    tick();
    drive(2'b00, 1'b0, 1'b1, 2'b11);
    chk("post_rst_rsp_valid", 204, 32'(rsv), 32'b01);
    chk("post_rst_rsp_ready", 204, 32'(irspr), 32'd1);
    chk("post_rst_busy1", 204, 32'(busy), 32'b01);
    tick();
    drive(2'b00, 1'b0, 1'b0, 2'b11);
    chk("post_rst_drained", 205, 32'(irspr), 32'd0);
    chk("post_rst_idle", 205, 32'(busy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
